// File: rtl/alarm_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alarm_ctrl_pkg : shared state encoding, BCD limits and BCD helpers    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package alarm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2
  } state_t;

  localparam logic [2:0] HOUR_TENS_MAX       = 3'd2;
  localparam logic [3:0] HOUR_UNITS_MAX_AT_2 = 4'd3;
  localparam logic [2:0] MIN_TENS_MAX        = 3'd5;
  localparam logic [3:0] UNITS_MAX           = 4'd9;

  localparam int unsigned DB_CYC_DEFAULT   = 1_000_000;
  localparam int unsigned RING_CYC_DEFAULT = 1_500_000_000;

  typedef struct packed {
    logic [2:0] tens;
    logic [3:0] units;
  } bcd_pair_t;

  // 23 -> 00, units carry into tens
  function automatic bcd_pair_t hour_inc(input bcd_pair_t h);
    bcd_pair_t r;
    r = h;
    if (h.tens == HOUR_TENS_MAX && h.units == HOUR_UNITS_MAX_AT_2) begin
      r.tens  = 3'd0;
      r.units = 4'd0;
    end else if (h.units == UNITS_MAX) begin
      r.tens  = h.tens + 3'd1;
      r.units = 4'd0;
    end else begin
      r.units = h.units + 4'd1;
    end
    return r;
  endfunction

  // 59 -> 00, units carry into tens
  function automatic bcd_pair_t min_inc(input bcd_pair_t m);
    bcd_pair_t r;
    r = m;
    if (m.units == UNITS_MAX) begin
      r.units = 4'd0;
      r.tens  = (m.tens == MIN_TENS_MAX) ? 3'd0 : m.tens + 3'd1;
    end else begin
      r.units = m.units + 4'd1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alarm_ctrl_if : key, running-time and alarm-output bundle             |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface alarm_ctrl_if;

  logic       key_mode_n;
  logic       key_inc_n;
  logic       key_stop_n;
  logic [2:0] a1;
  logic [3:0] a2;
  logic [2:0] a3;
  logic [3:0] a4;
  logic [2:0] b1;
  logic [3:0] b2;
  logic [2:0] b3;
  logic [3:0] b4;
  logic       ring;
  logic       armed;
  logic [1:0] set_mode;

  modport master (
    output key_mode_n, key_inc_n, key_stop_n, a1, a2, a3, a4,
    input  b1, b2, b3, b4, ring, armed, set_mode
  );

  modport slave (
    input  key_mode_n, key_inc_n, key_stop_n, a1, a2, a3, a4,
    output b1, b2, b3, b4, ring, armed, set_mode
  );

endinterface
`default_nettype wire

// File: rtl/alarm_ctrl_key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_debounce : synchronise, debounce and edge-detect one active-low   |
// | push-button; one press pulse per debounced press. Revision 1.0        |
// +----------------------------------------------------------------------+
module key_debounce #(
  parameter int unsigned DB_CYC = 1_000_000
) (
  input  logic mclk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CNT_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      // Any sample equal to the current level restarts the stability window
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_W'(DB_CYC - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
          r_press <= ~r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/alarm_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alarm_ctrl : alarm edit FSM, arm toggle, ring enable with stop and    |
// | timeout silencing. Revision 1.0                                       |
// +----------------------------------------------------------------------+
module alarm_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYC   = DB_CYC_DEFAULT,
  parameter int unsigned RING_CYC = RING_CYC_DEFAULT
) (
  input  logic         mclk,
  input  logic         rst_n,
  alarm_ctrl_if.slave  bus
);

  localparam int unsigned RC_W = $clog2(RING_CYC + 1);

  logic            w_press_mode;
  logic            w_press_inc;
  logic            w_press_stop;

  state_t          r_state;
  state_t          w_state_nxt;
  bcd_pair_t       r_hour;
  bcd_pair_t       w_hour_nxt;
  bcd_pair_t       r_min;
  bcd_pair_t       w_min_nxt;
  logic            r_armed;
  logic            w_armed_nxt;

  logic            w_match;
  logic            w_ring_nxt;
  logic            w_timeout;
  logic            r_ring;
  logic            r_silenced;
  logic [RC_W-1:0] r_ring_cnt;

  key_debounce #(.DB_CYC(DB_CYC)) u_db_mode (
    .mclk  (mclk),
    .rst_n (rst_n),
    .key_n (bus.key_mode_n),
    .press (w_press_mode)
  );

  key_debounce #(.DB_CYC(DB_CYC)) u_db_inc (
    .mclk  (mclk),
    .rst_n (rst_n),
    .key_n (bus.key_inc_n),
    .press (w_press_inc)
  );

  key_debounce #(.DB_CYC(DB_CYC)) u_db_stop (
    .mclk  (mclk),
    .rst_n (rst_n),
    .key_n (bus.key_stop_n),
    .press (w_press_stop)
  );

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_hour  <= '0;
      r_min   <= '0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hour  <= w_hour_nxt;
      r_min   <= w_min_nxt;
      r_armed <= w_armed_nxt;
    end
  end

  // Mode takes priority: a simultaneous inc is dropped
  always_comb begin
    w_state_nxt = r_state;
    w_hour_nxt  = r_hour;
    w_min_nxt   = r_min;
    w_armed_nxt = r_armed;
    if (w_press_mode) begin
      case (r_state)
        ST_RUN:   w_state_nxt = ST_SET_H;
        ST_SET_H: w_state_nxt = ST_SET_M;
        default:  w_state_nxt = ST_RUN;
      endcase
    end else if (w_press_inc) begin
      case (r_state)
        ST_SET_H: w_hour_nxt  = hour_inc(r_hour);
        ST_SET_M: w_min_nxt   = min_inc(r_min);
        default:  w_armed_nxt = ~r_armed;
      endcase
    end
  end

  assign w_match    = ({bus.a1, bus.a2, bus.a3, bus.a4} == {r_hour, r_min});
  assign w_ring_nxt = r_armed & w_match & ~r_silenced & (r_state == ST_RUN);
  // r_ring_cnt holds the number of cycles ring has been high, current included
  assign w_timeout  = (r_ring_cnt == RC_W'(RING_CYC - 1));

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_ring     <= 1'b0;
      r_silenced <= 1'b0;
      r_ring_cnt <= '0;
    end else begin
      r_ring     <= w_ring_nxt;
      r_ring_cnt <= w_ring_nxt ? r_ring_cnt + 1'b1 : '0;
      if (!w_match) begin
        r_silenced <= 1'b0;
      end else if (w_press_stop || w_timeout) begin
        r_silenced <= 1'b1;
      end
    end
  end

  assign bus.b1       = r_hour.tens;
  assign bus.b2       = r_hour.units;
  assign bus.b3       = r_min.tens;
  assign bus.b4       = r_min.units;
  assign bus.ring     = r_ring;
  assign bus.armed    = r_armed;
  assign bus.set_mode = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alarm_ctrl : table, directed and random checks of alarm_ctrl       |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_alarm_ctrl;

  localparam int DB = 8;
  localparam int RC = 100;

  localparam int OP_MODE = 0;
  localparam int OP_INC  = 1;

  typedef struct {
    int op;
    int reps;
    int exp_alarm;  // minutes since 00:00
    int exp_armed;
    int exp_mode;
  } vec_t;

  logic mclk  = 1'b0;
  logic rst_n = 1'b0;
  always #5 mclk = ~mclk;

  alarm_ctrl_if bus ();

  alarm_ctrl #(.DB_CYC(DB), .RING_CYC(RC)) dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int m_alarm;
  int m_armed;
  int m_mode;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int t);
    int h, m;
    h = t / 60;
    m = t % 60;
    return 32'((h / 10) * 1000 + (h % 10) * 100 + (m / 10) * 10 + (m % 10));
  endfunction

  function automatic logic [31:0] b_val();
    return 32'(bus.b1) * 32'd1000 + 32'(bus.b2) * 32'd100 + 32'(bus.b3) * 32'd10 + 32'(bus.b4);
  endfunction

  task automatic set_a(input int t);
    int h, m;
    h = t / 60;
    m = t % 60;
    bus.a1 = 3'(h / 10);
    bus.a2 = 4'(h % 10);
    bus.a3 = 3'(m / 10);
    bus.a4 = 4'(m % 10);
  endtask

  task automatic press(input bit m, input bit i, input bit s);
    @(negedge mclk);
    bus.key_mode_n = !m;
    bus.key_inc_n  = !i;
    bus.key_stop_n = !s;
    repeat (DB + 5) @(negedge mclk);
    bus.key_mode_n = 1'b1;
    bus.key_inc_n  = 1'b1;
    bus.key_stop_n = 1'b1;
    repeat (DB + 5) @(negedge mclk);
  endtask

  task automatic check_state(input string name, input int alarm, input int armed, input int mode);
    check({name, "_alarm"}, b_val(), enc(alarm));
    check({name, "_armed"}, 32'(bus.armed), 32'(armed));
    check({name, "_mode"},  32'(bus.set_mode), 32'(mode));
  endtask

  // Running time whose minutes sit 30 away from the alarm, so no single inc can match
  task automatic pick_mismatch();
    int h;
    h = int'($urandom_range(23, 0));
    set_a(h * 60 + ((m_alarm % 60) + 30) % 60);
  endtask

  initial begin
    int hi;
    int stayed0;
    int op;
    int hh, mm;

    tbl[0]  = '{OP_MODE, 1,    0, 0, 1};
    tbl[1]  = '{OP_INC, 19, 1140, 0, 1};
    tbl[2]  = '{OP_INC,  1, 1200, 0, 1};
    tbl[3]  = '{OP_INC,  3, 1380, 0, 1};
    tbl[4]  = '{OP_INC,  1,    0, 0, 1};
    tbl[5]  = '{OP_INC,  7,  420, 0, 1};
    tbl[6]  = '{OP_MODE, 1,  420, 0, 2};
    tbl[7]  = '{OP_INC, 59,  479, 0, 2};
    tbl[8]  = '{OP_INC,  1,  420, 0, 2};
    tbl[9]  = '{OP_MODE, 1,  420, 0, 0};
    tbl[10] = '{OP_INC,  1,  420, 1, 0};
    tbl[11] = '{OP_MODE, 2,  420, 1, 2};
    tbl[12] = '{OP_INC, 30,  450, 1, 2};
    tbl[13] = '{OP_MODE, 1,  450, 1, 0};

    bus.key_mode_n = 1'b1;
    bus.key_inc_n  = 1'b1;
    bus.key_stop_n = 1'b1;
    set_a(12 * 60 + 45);
    repeat (3) @(negedge mclk);
    rst_n = 1'b1;
    @(negedge mclk);
    check_state("reset", 0, 0, 0);
    check("reset_ring", 32'(bus.ring), 32'd0);

    bus.key_inc_n = 1'b0;
    repeat (5) @(negedge mclk);
    bus.key_inc_n = 1'b1;
    repeat (DB + 5) @(negedge mclk);
    check("glitch_armed", 32'(bus.armed), 32'd0);

    for (int k = 0; k < 14; k++) begin
      for (int r = 0; r < tbl[k].reps; r++) begin
        press(tbl[k].op == OP_MODE, tbl[k].op == OP_INC, 1'b0);
      end
      check_state($sformatf("tbl%0d", k), tbl[k].exp_alarm, tbl[k].exp_armed, tbl[k].exp_mode);
      check($sformatf("tbl%0d_ring", k), 32'(bus.ring), 32'd0);
    end

    // Ring, then stop: ring low exactly at press+2
    @(negedge mclk);
    set_a(450);
    check("ring_pre", 32'(bus.ring), 32'd0);
    @(negedge mclk);
    check("ring_on", 32'(bus.ring), 32'd1);
    bus.key_stop_n = 1'b0;
    repeat (DB + 3) @(negedge mclk);
    check("ring_before_stop", 32'(bus.ring), 32'd1);
    @(negedge mclk);
    check("ring_stop_p2", 32'(bus.ring), 32'd0);
    repeat (DB + 3) @(negedge mclk);
    bus.key_stop_n = 1'b1;
    repeat (DB + 5) @(negedge mclk);
    check("ring_silenced_hold", 32'(bus.ring), 32'd0);
    set_a(451);
    @(negedge mclk);
    check("ring_mismatch", 32'(bus.ring), 32'd0);
    set_a(450);
    @(negedge mclk);
    check("ring_rearm", 32'(bus.ring), 32'd1);

    hi = 1;
    while (bus.ring === 1'b1 && hi < 300) begin
      @(negedge mclk);
      if (bus.ring === 1'b1) hi++;
    end
    check("timeout_len", 32'(hi), 32'd100);
    stayed0 = 1;
    repeat (30) begin
      @(negedge mclk);
      if (bus.ring !== 1'b0) stayed0 = 0;
    end
    check("timeout_stays_low", 32'(stayed0), 32'd1);
    set_a(451);
    @(negedge mclk);
    set_a(450);
    @(negedge mclk);
    check("ring_after_timeout", 32'(bus.ring), 32'd1);

    press(1'b1, 1'b0, 1'b0);
    check("set_h_while_ring", 32'(bus.ring), 32'd0);
    check_state("set_h_while_ring", 450, 1, 1);
    press(1'b1, 1'b1, 1'b0);
    check_state("mode_and_inc", 450, 1, 2);
    press(1'b1, 1'b0, 1'b0);
    check("ring_back_run", 32'(bus.ring), 32'd1);

    // Disarm while ringing: armed at press+1, ring at press+2
    bus.key_inc_n = 1'b0;
    repeat (DB + 3) @(negedge mclk);
    check("disarm_armed", 32'(bus.armed), 32'd0);
    check("disarm_ring_p1", 32'(bus.ring), 32'd1);
    @(negedge mclk);
    check("disarm_ring_p2", 32'(bus.ring), 32'd0);
    bus.key_inc_n = 1'b1;
    repeat (DB + 5) @(negedge mclk);

    set_a(12 * 60 + 45);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    check_state("pre_reset", 452, 1, 2);
    @(negedge mclk);
    #2 rst_n = 1'b0;
    #1;
    check_state("async_reset", 0, 0, 0);
    check("async_reset_ring", 32'(bus.ring), 32'd0);
    repeat (2) @(negedge mclk);
    rst_n = 1'b1;

    m_alarm = 0;
    m_armed = 0;
    m_mode  = 0;
    pick_mismatch();
    for (int it = 0; it < 60; it++) begin
      op = int'($urandom_range(3, 0));
      if (op == 3) begin
        set_a(m_alarm);
        repeat (2) @(negedge mclk);
        check($sformatf("rnd%0d_ring", it), 32'(bus.ring), 32'((m_armed == 1 && m_mode == 0) ? 1 : 0));
        if ($urandom_range(1, 0) == 1) begin
          press(1'b0, 1'b0, 1'b1);
          check($sformatf("rnd%0d_stop", it), 32'(bus.ring), 32'd0);
        end
        pick_mismatch();
        @(negedge mclk);
      end else begin
        if (op == 0) begin
          press(1'b1, 1'b0, 1'b0);
          m_mode = (m_mode + 1) % 3;
        end else begin
          press(1'b0, 1'b1, 1'b0);
          hh = m_alarm / 60;
          mm = m_alarm % 60;
          if (m_mode == 0) m_armed = 1 - m_armed;
          else if (m_mode == 1) m_alarm = ((hh + 1) % 24) * 60 + mm;
          else m_alarm = hh * 60 + (mm + 1) % 60;
        end
        check_state($sformatf("rnd%0d", it), m_alarm, m_armed, m_mode);
        check($sformatf("rnd%0d_ring", it), 32'(bus.ring), 32'd0);
        pick_mismatch();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
